// File: rtl/gf_mul_if.sv
// Operand/product handshake bundle for the bit-serial GF(2^M) multiplier.
// Both directions use valid/ready; the master presents operands and accepts products.
interface gf_mul_if #(
   parameter int M = 8
);
   logic         in_valid;
   logic         in_ready;
   logic [M-1:0] a;
   logic [M-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [M-1:0] product;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, product
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, product
   );
endinterface

// File: rtl/gf_serial_multiplier.sv
// Bit-serial GF(2^M) standard-basis multiplier: accept -> product valid after M RUN cycles.
// Operands are taken only in IDLE; the product holds in DONE until out_ready.
module gf_serial_multiplier #(
   parameter int M = 8
) (
   input  logic     clk,
   input  logic     rst_n,
   gf_mul_if.slave  bus
);

   localparam int CW = $clog2(M) + 1;

   // Primitive polynomial, leading x^M term dropped.
   function automatic logic [M-1:0] poly_low(input int m);
      logic [31:0] p;
      case (m)
         2:       p = 32'h0000_0007;
         3:       p = 32'h0000_000B;
         4:       p = 32'h0000_0013;
         5:       p = 32'h0000_0025;
         6:       p = 32'h0000_0043;
         7:       p = 32'h0000_0089;
         8:       p = 32'h0000_011D;
         9:       p = 32'h0000_0211;
         10:      p = 32'h0000_0409;
         11:      p = 32'h0000_0805;
         12:      p = 32'h0000_1053;
         13:      p = 32'h0000_201B;
         14:      p = 32'h0000_4443;
         15:      p = 32'h0000_8003;
         16:      p = 32'h0001_002D;
         default: p = 32'h0000_0003;
      endcase
      return p[M-1:0];
   endfunction

   localparam logic [M-1:0]  POLY     = poly_low(M);
   localparam logic [CW-1:0] CNT_LAST = CW'(M - 1);

   function automatic logic [M-1:0] mul1(input logic [M-1:0] x);
      return {x[M-2:0], 1'b0} ^ (x[M-1] ? POLY : '0);
   endfunction

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [M-1:0]  sh_q, sh_d;
   logic [M-1:0]  breg_q, breg_d;
   logic [M-1:0]  acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sh_q    <= '0;
         breg_q  <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         breg_q  <= breg_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      breg_d  = breg_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               sh_d    = bus.a;
               breg_d  = bus.b;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            // Horner step: consume the multiplicand MSB first.
            acc_d = mul1(acc_q) ^ (sh_q[M-1] ? breg_q : '0);
            sh_d  = sh_q << 1;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.product   = acc_q;

endmodule
